// File: rtl/uart_frame_tx_pkg.sv
// Shared UART definitions: FSM state encoding and bit-period arithmetic,
// also used by the matching receiver and its timeout logic.
package uart_frame_tx_pkg;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Clock cycles per bit: integer division of system clock by line rate.
    function automatic int unsigned bit_cycles(input int unsigned clk_mhz,
                                               input int unsigned baud_rate);
        return (clk_mhz * 1000000) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Frame handshake between the bus-to-host memory interface and the UART transmitter.
interface uart_frame_tx_if #(
    parameter int unsigned DATA_MAX_LEN = 9
);
    logic [DATA_MAX_LEN*8-1:0] data;
    logic [7:0]                len_1;
    logic                      send;
    logic                      resend;
    logic                      ready;

    modport master (output data, output len_1, output send, output resend, input ready);
    modport slave  (input data, input len_1, input send, input resend, output ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Reloadable bit-period counter: one-cycle tick every BIT enabled cycles,
// restarted at frame start so the first period is full length.
module uart_baud_tick
    import uart_frame_tx_pkg::*;
#(
    parameter int unsigned BIT = 2604
) (
    input  logic clk,
    input  logic res_n,
    input  logic restart,
    input  logic en,
    output logic tick_c
);
    logic [CNT_W-1:0] cnt_q;

    assign tick_c = en && (cnt_q == CNT_W'(BIT - 1));

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_q <= '0;
        end else if (restart) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/uart_frame_tx.sv
// Multi-byte 8N1 UART transmitter; latches a frame and replays it on resend.
module uart_frame_tx
    import uart_frame_tx_pkg::*;
#(
    parameter int unsigned CLK          = 25,
    parameter int unsigned BAUD_RATE    = 9600,
    parameter int unsigned DATA_MAX_LEN = 9
) (
    input  logic            clk,
    input  logic            res_n,
    uart_frame_tx_if.slave  bus,
    output logic            tx
);
    localparam int unsigned BIT     = bit_cycles(CLK, BAUD_RATE);
    localparam int unsigned FRAME_W = DATA_MAX_LEN * 8;

    uart_state_e          state_q, state_nxt;
    logic [FRAME_W-1:0]   frame_q, frame_nxt;
    logic [BYTE_W-1:0]    len_q, len_nxt;
    logic [BYTE_W-1:0]    byte_q, byte_nxt;
    logic [2:0]           bit_q, bit_nxt;
    logic                 tx_nxt;
    logic                 ready_q;
    logic                 restart;
    logic                 tick;
    logic [7:0]           cur_byte;

    assign bus.ready = ready_q;

    uart_baud_tick #(.BIT(BIT)) u_tick (
        .clk     (clk),
        .res_n   (res_n),
        .restart (restart),
        .en      (state_q != ST_IDLE),
        .tick_c  (tick)
    );

    // Byte currently on the line; byte index never exceeds the clamped length.
    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < int'(DATA_MAX_LEN); i++) begin
            if (byte_q == BYTE_W'(i)) cur_byte = frame_q[8*i +: 8];
        end
    end

    always_comb begin
        state_nxt = state_q;
        frame_nxt = frame_q;
        len_nxt   = len_q;
        byte_nxt  = byte_q;
        bit_nxt   = bit_q;
        tx_nxt    = tx;
        restart   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tx_nxt = 1'b1;
                if (bus.send || bus.resend) begin
                    if (bus.send) begin
                        frame_nxt = bus.data;
                        len_nxt   = (bus.len_1 >= BYTE_W'(DATA_MAX_LEN)) ?
                                    BYTE_W'(DATA_MAX_LEN - 1) : bus.len_1;
                    end
                    byte_nxt  = '0;
                    restart   = 1'b1;
                    tx_nxt    = 1'b0;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    bit_nxt   = '0;
                    tx_nxt    = cur_byte[0];
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = ST_STOP;
                    end else begin
                        bit_nxt = bit_q + 3'd1;
                        tx_nxt  = cur_byte[bit_q + 3'd1];
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (byte_q == len_q) begin
                        tx_nxt    = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        byte_nxt  = byte_q + BYTE_W'(1);
                        tx_nxt    = 1'b0;
                        state_nxt = ST_START;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            len_q   <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            tx      <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_nxt;
            frame_q <= frame_nxt;
            len_q   <= len_nxt;
            byte_q  <= byte_nxt;
            bit_q   <= bit_nxt;
            tx      <= tx_nxt;
            ready_q <= (state_nxt == ST_IDLE);
        end
    end
endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx with CLK=1 MHz, 100 kbit/s (BIT=10 cycles).
module tb_uart_frame_tx;
    localparam int BIT = 10;
    localparam int DML = 9;

    typedef struct {
        logic          snd;
        logic          rsnd;
        logic [7:0]    len_1;
        logic [71:0]   data;
        int            pulse_at;
        int            nbytes;
        logic [71:0]   exp;
    } vec_t;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    logic tx;
    int   total = 0;
    int   bad = 0;

    uart_frame_tx_if #(.DATA_MAX_LEN(DML)) bus();

    uart_frame_tx #(.CLK(1), .BAUD_RATE(100000), .DATA_MAX_LEN(DML)) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_tx(input logic [71:0] bytes, input int c);
        int bp = c / BIT;
        int k = bp % 10;
        logic [7:0] b;
        logic [71:0] tmp = bytes >> (8 * (bp / 10));
        b = tmp[7:0];
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // Starts a frame, then checks every cycle of the expected waveform and the
    // exact point where ready rises again.
    task automatic run_frame(input string name, input vec_t v, input int abort_at);
        chk({name, " ready_before"}, 32'(bus.ready), 32'd1);
        bus.send   = v.snd;
        bus.resend = v.rsnd;
        bus.len_1  = v.len_1;
        bus.data   = v.data;
        step();
        bus.send   = 1'b0;
        bus.resend = 1'b0;
        for (int c = 0; c < v.nbytes * 10 * BIT; c++) begin
            if (c == abort_at) return;
            chk($sformatf("%s tx c=%0d", name, c), 32'(tx), 32'(exp_tx(v.exp, c)));
            chk($sformatf("%s ready c=%0d", name, c), 32'(bus.ready), 32'd0);
            if (c == 0) begin
                bus.data  = {9{8'h5A}};
                bus.len_1 = 8'd7;
            end
            if (c == v.pulse_at) bus.send = 1'b1;
            if (c == v.pulse_at + 1) bus.send = 1'b0;
            step();
        end
        chk({name, " ready_after"}, 32'(bus.ready), 32'd1);
        chk({name, " tx_after"}, 32'(tx), 32'd1);
    endtask

    initial begin
        vec_t vecs[4];
        vec_t v;

        vecs[0] = '{1'b1, 1'b0, 8'd0, 72'hA5, -1, 1, 72'hA5};
        vecs[1] = '{1'b1, 1'b0, 8'd3, 72'h04030201, -1, 4, 72'h04030201};
        vecs[2] = '{1'b0, 1'b1, 8'd0, 72'h0, -1, 4, 72'h04030201};
        vecs[3] = '{1'b1, 1'b1, 8'd1, 72'h3CC3, 50, 2, 72'h3CC3};

        bus.send   = 1'b0;
        bus.resend = 1'b0;
        bus.len_1  = 8'd0;
        bus.data   = '0;
        #23 res_n = 1'b1;
        step();

        for (int c = 0; c < 100; c++) begin
            chk($sformatf("idle tx c=%0d", c), 32'(tx), 32'd1);
            chk($sformatf("idle ready c=%0d", c), 32'(bus.ready), 32'd1);
            step();
        end

        for (int i = 0; i < 4; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i], -1);
            step();
        end

        // Reset 35 cycles into a one-byte frame must force the line idle at once.
        v = '{1'b1, 1'b0, 8'd0, 72'h81, -1, 1, 72'h81};
        run_frame("pre_reset", v, 35);
        res_n = 1'b0;
        #1;
        chk("reset tx", 32'(tx), 32'd1);
        chk("reset ready", 32'(bus.ready), 32'd1);
        step();
        step();
        #2 res_n = 1'b1;
        step();
        chk("post_reset tx", 32'(tx), 32'd1);

        // Resend straight after reset replays the cleared one-byte frame.
        v = '{1'b0, 1'b1, 8'd0, 72'h0, -1, 1, 72'h00};
        run_frame("resend_zero", v, -1);
        step();

        // Oversized length clamps to nine bytes.
        v = '{1'b1, 1'b0, 8'd20, 72'h998877665544332211, -1, 9, 72'h998877665544332211};
        run_frame("clamp", v, -1);
        step();
        chk("final ready", 32'(bus.ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Multi-byte UART transmitter: latches a frame of up to DATA_MAX_LEN bytes and serialises it on tx, 8N1, least-significant byte first.
- Sits directly downstream of the bus-to-host memory interface. That interface presents a packed command frame with a byte count, pulses send (or resend after an rx timeout), and waits on ready.
- Holds the last frame so resend can replay it without the upstream re-driving data.

Parameters:
- CLK, 25, system clock frequency in MHz (integer).
- BAUD_RATE, 9600, line rate in bit/s.
- DATA_MAX_LEN, 9, maximum frame length in bytes.

Ports:
- clk  input  1  system clock, all state on rising edge.
- res_n  input  1  asynchronous, active-low reset.
- data  input  DATA_MAX_LEN*8  frame; byte i = data[8i+7:8i], byte 0 sent first.
- len_1  input  8  frame length minus one, in bytes.
- send  input  1  start a new frame; sampled only while ready=1.
- resend  input  1  replay the last latched frame; sampled only while ready=1.
- ready  output  1  idle and able to accept send/resend.
- tx  output  1  serial line, idle high.

Behaviour:
- Bit period BIT = CLK*1000000/BAUD_RATE clock cycles, integer division. Defaults give 2604.
- Reset: state IDLE, tx=1, ready=1, bit counter, byte index and latched frame/length all cleared. Reset mid-frame aborts immediately and drives tx high asynchronously.
- States: IDLE, START, DATA, STOP. ready = (state==IDLE); it is registered state, not a combinational function of send.
- IDLE:
  - send=1 at an edge: latch data into frameReg and len_1 into lenReg, clear byte index, go to START.
  - else resend=1: keep frameReg/lenReg, clear byte index, go to START.
  - Both asserted: send wins.
- send/resend while ready=0: ignored, no effect on the current frame.
- Latency: the edge that samples send makes tx=0 and ready=0 from the next cycle. The upstream FSM therefore never sees ready=1 in the cycle after its send.
- START: tx=0 for BIT cycles, then DATA with bit index 0.
- DATA:
  - tx = current byte bit[bitIdx], LSB first, each bit held BIT cycles.
  - After bit 7 go to STOP.
- STOP: tx=1 for BIT cycles. Then:
  - if byteIdx == lenReg: go to IDLE, ready=1 next cycle.
  - else: byteIdx+1 and back to START, with no extra idle between bytes.
- Frame duration from the send edge to ready rising = (lenReg+1)*10*BIT cycles exactly.
- len_1 >= DATA_MAX_LEN is clamped to DATA_MAX_LEN-1 at latch time.
- len_1=0 sends exactly one byte.
- Bit counter is 32 bits, wraps to 0 at BIT-1. Byte index is 8 bits.
- data and len_1 may change freely after the sampling edge; only latched copies are used.
- resend before any send after reset: replays an all-zero 1-byte frame (lenReg=0).

Decomposition:
- Shared package/header:
  - state encodings (2-bit IDLE/START/DATA/STOP);
  - macro computing BIT from CLK and BAUD_RATE, also used by the matching rx block and its timeout.
- One natural sub-module: uart_baud_tick. It is a reloadable counter producing a one-cycle tick every BIT cycles, restarted on frame start, and can be shared with the receiver.

Test Plan (CLK=1, BAUD_RATE=100000, so BIT=10; DATA_MAX_LEN=9):
- Reset release, no stimulus -> tx=1, ready=1 held for 100 cycles.
- send with len_1=0, data[7:0]=8'hA5 -> tx low at next cycle for 10 cycles, then bits 1,0,1,0,0,1,0,1 (10 cycles each), stop high 10 cycles. ready low exactly 100 cycles, then high.
- send with len_1=3, data[31:0]=32'h04030201 -> bytes 01,02,03,04 in order, back-to-back, ready low exactly 400 cycles. Changing data the cycle after send does not alter output.
- After the previous frame, resend with data=0 -> identical 400-cycle waveform carrying 01,02,03,04.
- send and resend together, then send pulsed again at cycle 50 of a frame -> new frame latched, mid-frame send ignored, one frame's duration only.
- res_n low at cycle 35 of a 1-byte frame -> tx=1 and ready=1 immediately. After release, send len_1=20 -> clamped, 9 bytes sent, ready low 900 cycles.
